// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the period and high time of a divided clock
// (sig_in) in system clock cycles, single-shot or continuous, and compares
// each measured period against exp_period.
//
// Compile-time option: CLK_DIV_MONITOR_SYNC_EN
//   defined   - sig_in passes through a two-flop synchronizer before the
//               capture flop (for sig_in asynchronous to clk)
//   undefined - sig_in is registered once (sig_in derived from clk)
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   sig_in     in   divided clock under test
//   start      in   one-cycle measurement request, honoured only when idle
//   cont       in   1 = continuous measurement, 0 = single-shot
//   exp_period in   expected period in clk cycles
//   period     out  last measured period
//   high_time  out  last measured high-cycle count
//   valid      out  one-cycle pulse when period/high_time/match update
//   match      out  period == exp_period for the last result
//   busy       out  measurement in progress (ARM or MEASURE)
//   timeout    out  sticky abort flag, cleared by an accepted start
module clk_div_monitor #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(2048)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic [WIDTH-1:0] exp_period,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             match,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_sig_pre;
  logic             r_sig_s;
  logic             r_sig_d;
  logic             w_rise;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_hi_inc;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic             w_start_acc;
  logic             w_capture;
  logic             w_abort;

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_valid;
  logic             r_match;
  logic             r_busy;
  logic             r_timeout;

`ifdef CLK_DIV_MONITOR_SYNC_EN
  // Two-flop synchronizer ahead of the common capture flop
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sig_pre = r_sync2;
`else
  assign w_sig_pre = sig_in;
`endif

  // Capture flop and edge-detect delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_s <= 1'b0;
      r_sig_d <= 1'b0;
    end else begin
      r_sig_s <= w_sig_pre;
      r_sig_d <= r_sig_s;
    end
  end

  assign w_rise    = r_sig_s & ~r_sig_d;
  // r_cnt doubles as the watchdog; it never passes TIMEOUT so cannot wrap
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_hi_inc  = r_hi + WIDTH'(r_sig_s);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a rise wins over a simultaneous watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
        end else if (w_cnt_inc == TIMEOUT) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          if (!cont) begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_cnt_inc == TIMEOUT) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath control: counter updates, capture and abort strobes
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_start_acc = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_cnt_nxt   = '0;
          w_hi_nxt    = '0;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_cnt_nxt = WIDTH'(1);
          w_hi_nxt  = WIDTH'(1);
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_abort   = (w_cnt_inc == TIMEOUT);
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          // The rising cycle is the first (high) cycle of the next period
          w_capture = 1'b1;
          w_cnt_nxt = WIDTH'(1);
          w_hi_nxt  = WIDTH'(1);
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_hi_nxt  = w_hi_inc;
          w_abort   = (w_cnt_inc == TIMEOUT);
        end
      end
      default: begin
        w_cnt_nxt = '0;
        w_hi_nxt  = '0;
      end
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_hi        <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_match     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_valid <= w_capture;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_period    <= r_cnt;
        r_high_time <= r_hi;
        r_match     <= (r_cnt == exp_period);
      end
      if (w_start_acc) begin
        r_timeout <= 1'b0;
      end else if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign valid     = r_valid;
  assign match     = r_match;
  assign busy      = r_busy;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: square-wave divider stimulus with
// hand-computed period / high-time / timing expectations.
module tb_clk_div_monitor;

  localparam int unsigned WIDTH = 28;
`ifdef CLK_DIV_MONITOR_SYNC_EN
  localparam int RISE_LAT = 3;
`else
  localparam int RISE_LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic             cont;
  logic [WIDTH-1:0] exp_period;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             match;
  logic             busy;
  logic             timeout;

  int n_vec;
  int n_err;
  int edge_cnt;
  int rise_edge;
  int div_n;
  int ph;

  clk_div_monitor #(
    .WIDTH  (WIDTH),
    .TIMEOUT(28'd2048)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .cont      (cont),
    .exp_period(exp_period),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .match     (match),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Square-wave divider: high for div_n/2 cycles, low for div_n/2; held low
  // when div_n is 0. Records the posedge index at which each rise is sampled.
  always @(negedge clk) begin
    if (div_n == 0) begin
      sig_in = 1'b0;
    end else begin
      if ((ph < div_n / 2) && !sig_in) rise_edge = edge_cnt + 1;
      sig_in = (ph < div_n / 2);
      ph = (ph + 1) % div_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int n);
    div_n = n;
    ph    = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid === 1'b1) begin
        got = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({period, high_time, valid, match, busy, timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {period, high_time, valid, match, busy, timeout});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_div2_single();
    bit got;
    int nv;
    set_div(2);
    cont       = 1'b0;
    exp_period = 28'd2;
    tick();
    tick();
    pulse_start();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL div2_busy_after_start: got %b expected 1", busy);
    end
    wait_valid(20, got);
    n_vec++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL div2_valid_seen: got %b expected 1", got);
    end
    n_vec++;
    if ({period, high_time, match, busy} !== {28'd2, 28'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL div2_result: got period=%0d high=%0d match=%b busy=%b expected 2 1 1 0",
               period, high_time, match, busy);
    end
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL div2_single_shot_extra_valid: got %0d expected 0", nv);
    end
  endtask

  task automatic test_div1024_match();
    bit got;
    set_div(1024);
    cont       = 1'b0;
    exp_period = 28'd1024;
    pulse_start();
    wait_valid(3000, got);
    n_vec++;
    if ({got, period, high_time, match} !== {1'b1, 28'd1024, 28'd512, 1'b1}) begin
      n_err++;
      $display("FAIL div1024_match: got valid=%b period=%0d high=%0d match=%b expected 1 1024 512 1",
               got, period, high_time, match);
    end
    exp_period = 28'd1000;
    pulse_start();
    wait_valid(3000, got);
    n_vec++;
    if ({got, period, high_time, match} !== {1'b1, 28'd1024, 28'd512, 1'b0}) begin
      n_err++;
      $display("FAIL div1024_nomatch: got valid=%b period=%0d high=%0d match=%b expected 1 1024 512 0",
               got, period, high_time, match);
    end
  endtask

  task automatic test_cont_div8();
    bit got;
    int gap;
    int nv;
    set_div(8);
    cont       = 1'b1;
    exp_period = 28'd8;
    pulse_start();
    wait_valid(40, got);
    n_vec++;
    if ({got, period, high_time} !== {1'b1, 28'd8, 28'd4}) begin
      n_err++;
      $display("FAIL cont8_first: got valid=%b period=%0d high=%0d expected 1 8 4",
               got, period, high_time);
    end
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        gap++;
        if (valid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      n_vec++;
      if ({got, gap, period, high_time, busy} !== {1'b1, 32'd8, 28'd8, 28'd4, 1'b1}) begin
        n_err++;
        $display("FAIL cont8_gap%0d: got valid=%b gap=%0d period=%0d high=%0d busy=%b expected 1 8 8 4 1",
                 k, got, gap, period, high_time, busy);
      end
    end
    cont = 1'b0;
    wait_valid(20, got);
    n_vec++;
    if ({got, period, busy} !== {1'b1, 28'd8, 1'b0}) begin
      n_err++;
      $display("FAIL cont8_stop: got valid=%b period=%0d busy=%b expected 1 8 0",
               got, period, busy);
    end
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL cont8_after_stop_valid: got %0d expected 0", nv);
    end
  endtask

  task automatic test_reset_mid_measure();
    int nv;
    int nb;
    set_div(512);
    cont       = 1'b0;
    exp_period = 28'd512;
    pulse_start();
    for (int i = 0; i < 300; i++) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({period, high_time, valid, match, busy, timeout} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {period, high_time, valid, match, busy, timeout});
    end
    #1;
    rst = 1'b0;
    nv = 0;
    nb = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (valid === 1'b1) nv++;
      if (busy === 1'b1) nb++;
    end
    n_vec++;
    if ({nv, nb} !== {32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL rst_mid_stays_idle: got valids=%0d busy_cycles=%0d expected 0 0", nv, nb);
    end
  endtask

  task automatic test_timeout();
    int nv;
    set_div(0);
    tick();
    tick();
    tick();
    pulse_start();
    nv = 0;
    for (int i = 0; i < 2047; i++) begin
      tick();
      if (valid === 1'b1) nv++;
    end
    n_vec++;
    if ({busy, timeout} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_before_limit: got busy=%b timeout=%b expected 1 0", busy, timeout);
    end
    tick();
    if (valid === 1'b1) nv++;
    n_vec++;
    if ({busy, timeout} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_at_limit: got busy=%b timeout=%b expected 0 1", busy, timeout);
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL timeout_no_valid: got %0d expected 0", nv);
    end
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
    pulse_start();
    n_vec++;
    if ({busy, timeout} !== 2'b10) begin
      n_err++;
      $display("FAIL timeout_cleared_by_start: got busy=%b timeout=%b expected 1 0", busy, timeout);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_start_while_busy();
    bit got;
    int nv;
    set_div(16);
    cont       = 1'b0;
    exp_period = 28'd16;
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    pulse_start();
    wait_valid(60, got);
    n_vec++;
    if ({got, period, high_time, match, busy} !== {1'b1, 28'd16, 28'd8, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL start_busy_result: got valid=%b period=%0d high=%0d match=%b busy=%b expected 1 16 8 1 0",
               got, period, high_time, match, busy);
    end
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid === 1'b1) nv++;
    end
    n_vec++;
    if (nv !== 0) begin
      n_err++;
      $display("FAIL start_busy_ignored: got %0d extra valids expected 0", nv);
    end
  endtask

  task automatic test_div4_latency();
    bit got;
    int lat;
    set_div(4);
    cont       = 1'b0;
    exp_period = 28'd4;
    pulse_start();
    wait_valid(30, got);
    lat = edge_cnt - rise_edge;
    n_vec++;
    if ({got, period, high_time, match} !== {1'b1, 28'd4, 28'd2, 1'b1}) begin
      n_err++;
      $display("FAIL div4_result: got valid=%b period=%0d high=%0d match=%b expected 1 4 2 1",
               got, period, high_time, match);
    end
    n_vec++;
    if (lat !== RISE_LAT) begin
      n_err++;
      $display("FAIL div4_latency: got %0d expected %0d", lat, RISE_LAT);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    edge_cnt   = 0;
    rise_edge  = 0;
    div_n      = 0;
    ph         = 0;
    sig_in     = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    exp_period = '0;

    test_reset();
    test_div2_single();
    test_div1024_match();
    test_cont_div8();
    test_reset_mid_measure();
    test_timeout();
    test_start_while_busy();
    test_div4_latency();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
